// File: rtl/div3_rr_if.sv
// Requester/result bundle for the shared divisible-by-3 engine.
// master = producers and result consumer, slave = the scheduler.
interface div3_rr_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_vld;
  logic [NREQ-1:0]        req_rdy;
  logic                   res_div3;
  logic [ID_W-1:0]        res_id;
  logic                   res_vld;
  logic                   res_rdy;
  logic                   busy;

  modport master (
    output req_data, req_vld, res_rdy,
    input  req_rdy, res_div3, res_id, res_vld, busy
  );

  modport slave (
    input  req_data, req_vld, res_rdy,
    output req_rdy, res_div3, res_id, res_vld, busy
  );
endinterface

// File: rtl/div3_rr_scheduler.sv
// Round-robin front end sharing one bit-serial mod-3 residue engine between
// NREQ requesters; verdicts return tagged with the owning requester index.
module div3_rr_scheduler #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  div3_rr_if.slave  bus
);
  localparam int              ID_W     = $clog2(NREQ);
  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [ID_W:0]   NREQ_EXT = (ID_W + 1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESULT} state_t;

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, r_res_id;
  logic [1:0]        r_residue, w_residue_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shift, w_cap_data;
  logic              r_res_vld, r_res_div3, r_busy;
  logic [NREQ-1:0]   w_vld_rot, w_req_rdy;
  logic              w_grant_vld;
  logic [ID_W:0]     w_grant_off, w_grant_sum;
  logic [ID_W-1:0]   w_grant_idx;

  // Rotate requests so bit 0 is the lane at rr_ptr, pick the first set bit,
  // then rotate the offset back into an absolute lane index.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    w_vld_rot   = NREQ'({bus.req_vld, bus.req_vld} >> r_rr_ptr);
    w_grant_vld = 1'b0;
    w_grant_off = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_grant_vld && w_vld_rot[i]) begin
        w_grant_vld = 1'b1;
        w_grant_off = (ID_W + 1)'(i);
      end
    end
    w_grant_sum = {1'b0, r_rr_ptr} + w_grant_off;
    w_grant_idx = (w_grant_sum >= NREQ_EXT) ? ID_W'(w_grant_sum - NREQ_EXT)
                                            : ID_W'(w_grant_sum);
  end

  always_comb begin
    w_cap_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == ID_W'(i)) w_cap_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Residue step r' = (2r + b) mod 3 for the MSB currently in the shifter.
  always_comb begin
    case ({r_residue, r_shift[DATA_W-1]})
      3'b000:  w_residue_nxt = 2'd0;
      3'b001:  w_residue_nxt = 2'd1;
      3'b010:  w_residue_nxt = 2'd2;
      3'b011:  w_residue_nxt = 2'd0;
      3'b100:  w_residue_nxt = 2'd1;
      3'b101:  w_residue_nxt = 2'd2;
      default: w_residue_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_vld)                w_state_nxt = S_CALC;
      S_CALC:   if (r_count == CNT_W'(1))       w_state_nxt = S_RESULT;
      S_RESULT: if (bus.res_rdy)                w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  // Grant is only offered in IDLE and is forced low while reset is held.
  always_comb begin
    w_req_rdy = '0;
    if (r_state == S_IDLE && w_grant_vld && !rst) w_req_rdy[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_res_id   <= '0;
      r_residue  <= 2'd0;
      r_count    <= '0;
      r_res_vld  <= 1'b0;
      r_res_div3 <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_res_vld <= (w_state_nxt == S_RESULT);
      r_busy    <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_res_id  <= w_grant_idx;
          r_residue <= 2'd0;
          r_count   <= CNT_LOAD;
          r_rr_ptr  <= (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + 1'b1;
        end
        S_CALC: begin
          r_residue <= w_residue_nxt;
          r_count   <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) r_res_div3 <= (w_residue_nxt == 2'd0);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the operand shifter is left without reset; it is always loaded at a grant before being read.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_grant_vld) r_shift <= w_cap_data;
    else if (r_state == S_CALC)           r_shift <= r_shift << 1;
  end

  assign bus.req_rdy  = w_req_rdy;
  assign bus.res_vld  = r_res_vld;
  assign bus.res_div3 = r_res_div3;
  assign bus.res_id   = r_res_id;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_div3_rr_scheduler.sv
// Bench for div3_rr_scheduler: directed scenarios with literal expectations
// plus a per-cycle comparison against an arithmetic model of the scheduler.
module tb_div3_rr_scheduler;
  localparam int NREQ   = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  div3_rr_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  div3_rr_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for work, 1 = computing, 2 = holding a result.
  int                m_state = 0;
  int                m_ptr   = 0;
  int                m_left  = 0;
  int                m_id    = 0;
  logic [DATA_W-1:0] m_op    = '0;

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_rdy();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = model_grant(bus.req_vld, m_ptr);
    if (m_state == 0 && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_ptr <= 0; m_left <= 0; m_id <= 0; m_op <= '0;
    end else begin
      case (m_state)
        0: if (model_grant(bus.req_vld, m_ptr) >= 0) begin
          m_id    <= model_grant(bus.req_vld, m_ptr);
          m_op    <= bus.req_data[model_grant(bus.req_vld, m_ptr)*DATA_W +: DATA_W];
          m_ptr   <= (model_grant(bus.req_vld, m_ptr) + 1) % NREQ;
          m_left  <= DATA_W;
          m_state <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_state <= 2;
        end
        default: if (bus.res_rdy) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("req_rdy", bus.req_rdy, exp_rdy());
      check("res_vld", bus.res_vld, m_state == 2);
      check("busy", bus.busy, m_state != 0);
      if (m_state == 2) begin
        check("res_div3", bus.res_div3, (m_op % 3) == 0);
        check("res_id", bus.res_id, m_id);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_vld = '0;
    bus.res_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Call near a falling edge; returns just after the rising edge that completes a handshake.
  task automatic wait_hs(output int lane, output int at);
    lane = -1;
    at   = 0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (|(bus.req_rdy & bus.req_vld)) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_rdy[i]) lane = i;
        at = cyc;
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    check("hs_timeout", 0, 1);
  endtask

  task automatic wait_res();
    int n = 0;
    while (!bus.res_vld && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.res_vld) check("res_timeout", 0, 1);
  endtask

  function automatic logic [DATA_W-1:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lane, at, prev, c0;
    int ops_a[4]   = '{0, 7, 9, 128};
    int div_a[4]   = '{1, 0, 1, 0};
    int order_a[5] = '{0, 1, 2, 3, 0};
    int order_b[4] = '{0, 2, 0, 2};
    int waits[NREQ];
    int last, ops, cycles;

    bus.req_data = '0;
    bus.req_vld  = '1;
    bus.res_rdy  = 1'b0;

    // Reset state, with every lane requesting
    #7;
    check("rst_req_rdy", bus.req_rdy, 4'b0000);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res_div3", bus.res_div3, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    bus.req_vld = '0;
    rst = 1'b0;

    // Single requester, lane 2, all-ones operand
    @(negedge clk);
    bus.req_data[2*DATA_W +: DATA_W] = 8'd255;
    bus.req_vld = 4'b0100;
    bus.res_rdy = 1'b1;
    #1;
    check("t1_grant", bus.req_rdy, 4'b0100);
    c0 = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.req_vld = '0;
    #1;
    check("t1_grant_once", bus.req_rdy, 4'b0000);
    wait_res();
    check("t1_latency", cyc - c0, 9);
    check("t1_div3", bus.res_div3, 1);
    check("t1_id", bus.res_id, 2);

    // Back-to-back operands on lane 0
    @(negedge clk);
    bus.req_data[0 +: DATA_W] = DATA_W'(ops_a[0]);
    bus.req_vld = 4'b0001;
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      wait_hs(lane, at);
      check("t2_lane", lane, 0);
      if (j > 0) check("t2_spacing", at - prev, DATA_W + 2);
      prev = at;
      @(negedge clk);
      if (j < 3) bus.req_data[0 +: DATA_W] = DATA_W'(ops_a[j+1]);
      else       bus.req_vld = '0;
      #1;
      wait_res();
      check("t2_div3", bus.res_div3, div_a[j]);
    end

    // All lanes requesting: strict rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(3*i + 1);
    bus.req_vld = 4'b1111;
    bus.res_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_hs(lane, at);
      check("t3_grant_all", lane, order_a[j]);
      @(negedge clk);
      #1;
      wait_res();
      check("t3_res_id_all", bus.res_id, order_a[j]);
    end
    do_reset();
    bus.req_vld = 4'b0101;
    bus.res_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_hs(lane, at);
      check("t3_grant_pair", lane, order_b[j]);
      @(negedge clk);
      #1;
      wait_res();
      check("t3_res_id_pair", bus.res_id, order_b[j]);
    end

    // Consumer stall in RESULT
    do_reset();
    bus.req_data[0 +: DATA_W]      = 8'd6;
    bus.req_data[DATA_W +: DATA_W] = 8'd5;
    bus.req_vld = 4'b0011;
    bus.res_rdy = 1'b0;
    wait_hs(lane, at);
    check("t4_first_lane", lane, 0);
    @(negedge clk);
    bus.req_vld = 4'b0010;
    #1;
    wait_res();
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_vld", bus.res_vld, 1);
      check("t4_hold_div3", bus.res_div3, 1);
      check("t4_hold_id", bus.res_id, 0);
      check("t4_hold_rdy", bus.req_rdy, 4'b0000);
      @(negedge clk);
      #1;
    end
    bus.res_rdy = 1'b1;
    @(negedge clk);
    bus.res_rdy = 1'b0;
    #1;
    check("t4_regrant", bus.req_rdy, 4'b0010);
    c0 = cyc;
    wait_hs(lane, at);
    check("t4_regrant_lane", lane, 1);
    check("t4_regrant_cycle", at - c0, 0);
    @(negedge clk);
    bus.req_vld = '0;
    bus.res_rdy = 1'b1;
    #1;
    wait_res();

    // Asynchronous reset during the 4th computing cycle
    do_reset();
    bus.req_vld = 4'b1111;
    bus.res_rdy = 1'b1;
    wait_hs(lane, at);
    repeat (3) @(posedge clk);
    #2;
    check("t5_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("t5_busy_rst", bus.busy, 0);
    check("t5_vld_rst", bus.res_vld, 0);
    check("t5_rdy_rst", bus.req_rdy, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_first_grant", bus.req_rdy, 4'b0001);
    wait_hs(lane, at);
    check("t5_first_lane", lane, 0);
    @(negedge clk);
    bus.req_vld = '0;
    #1;
    wait_res();

    // Random operands, lanes and consumer stalls
    do_reset();
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
    last = -1; ops = 0; cycles = 0;
    while (ops < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (last >= 0) bus.req_vld[last] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_vld[i]) begin
          bus.req_data[i*DATA_W +: DATA_W] = pick_op();
          if ($urandom_range(0, 2) == 0) begin
            bus.req_vld[i] = 1'b1;
            waits[i] = 0;
          end
        end
      end
      bus.res_rdy = ($urandom_range(0, 3) != 0);
      #1;
      last = -1;
      if (|(bus.req_rdy & bus.req_vld)) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_rdy[i]) last = i;
        check("fairness", waits[last] < NREQ, 1);
        for (int i = 0; i < NREQ; i++) if (i != last && bus.req_vld[i]) waits[i]++;
        ops++;
      end
    end
    check("random_ops_done", ops, 1000);
    @(negedge clk);
    if (last >= 0) bus.req_vld[last] = 1'b0;
    @(negedge clk);
    bus.req_vld = '0;
    bus.res_rdy = 1'b1;
    repeat (DATA_W + 4) @(negedge clk);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
